// File: rtl/radix8_seq_mult.sv
// Radix-8 digit-serial unsigned multiplier: P = A * I using the precomputed odd multiples I1/I3/I5/I7.
// Latency: NDIG cycles from the accept edge to out_valid (fixed, no early termination).
// Backpressure: in_ready only in IDLE; P and out_valid hold in DONE until out_ready.
module radix8_seq_mult #(
    parameter int LOG2_WIDTH = 4,
    parameter int WIDTH      = 2 ** LOG2_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH+2:0]   I1,
    input  logic [WIDTH+2:0]   I3,
    input  logic [WIDTH+2:0]   I5,
    input  logic [WIDTH+2:0]   I7,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P
);
    localparam int NDIG = (WIDTH + 2) / 3;
    localparam int AW   = 3 * NDIG;
    localparam int IW   = WIDTH + 3;
    localparam int ACCW = 2 * WIDTH + 3;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q;
    logic [AW-1:0]      a_q;
    logic [IW-1:0]      i1_q, i3_q, i5_q, i7_q;
    logic [ACCW-1:0]    acc_q, acc_d;
    logic [CW-1:0]      cnt_q;
    logic               in_ready_q, out_valid_q;
    logic [2*WIDTH-1:0] p_q;

    logic [2:0]         digit;
    logic [ACCW-1:0]    pp, pp_sh;

    // Digit select and shift are per-count muxes so every index stays constant.
    always_comb begin
        digit = 3'd0;
        pp    = '0;
        pp_sh = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (cnt_q == CW'(k)) digit = a_q[3*k +: 3];
        end
        case (digit)
            3'd0: pp = '0;
            3'd1: pp = ACCW'(i1_q);
            3'd2: pp = ACCW'(i1_q) << 1;
            3'd3: pp = ACCW'(i3_q);
            3'd4: pp = ACCW'(i1_q) << 2;
            3'd5: pp = ACCW'(i5_q);
            3'd6: pp = ACCW'(i3_q) << 1;
            3'd7: pp = ACCW'(i7_q);
            default: pp = '0;
        endcase
        for (int k = 0; k < NDIG; k++) begin
            if (cnt_q == CW'(k)) pp_sh = pp << (3 * k);
        end
        acc_d = acc_q + pp_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            i1_q        <= '0;
            i3_q        <= '0;
            i5_q        <= '0;
            i7_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= AW'(A);
                        i1_q       <= I1;
                        i3_q       <= I3;
                        i5_q       <= I5;
                        i7_q       <= I7;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NDIG - 1)) begin
                        p_q         <= acc_d[2*WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign P         = p_q;
endmodule

// File: tb/tb_radix8_seq_mult.sv
// Directed bench for radix8_seq_mult: a transaction-level model (product = A*I, fixed 6-cycle latency)
// is checked every cycle, and each directed vector is also checked against a hand-computed literal.
module tb_radix8_seq_mult;
    localparam int W    = 16;
    localparam int NDIG = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  i_val = '0;
    logic [W+2:0]  I1, I3, I5, I7;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*W-1:0] P;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    assign I1 = {3'b000, i_val};
    assign I3 = {3'b000, i_val} * 19'd3;
    assign I5 = {3'b000, i_val} * 19'd5;
    assign I7 = {3'b000, i_val} * 19'd7;

    radix8_seq_mult dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .A(A),
        .I1(I1), .I3(I3), .I5(I5), .I7(I7),
        .out_valid(out_valid), .out_ready(out_ready), .P(P)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: busy for NDIG cycles after an accept, then presents A*I until taken.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_age = 0;
    logic [31:0] m_prod = '0;
    logic [31:0] m_P = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_age  <= 0;
            m_P    <= '0;
        end else if (!m_busy && !m_done) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_prod <= {16'b0, A} * {16'b0, i_val};
            end
        end else if (m_busy) begin
            m_age <= m_age + 1;
            if (m_age + 1 == NDIG) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_P    <= m_prod;
            end
        end else if (out_ready) begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_in_ready", 64'(in_ready), 64'(!m_busy && !m_done));
            chk("model_out_valid", 64'(out_valid), 64'(m_done));
            chk("model_P", 64'(P), 64'(m_P));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, optionally poke in_valid mid-run and stall the output.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] i,
                          input logic [31:0] exp_p, input int hold, input bit poke);
        int n;
        A = a;
        i_val = i;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = 16'hA5A5;
        i_val = 16'h5A5A;
        n = 0;
        while (!out_valid && n < 20) begin
            if (poke && n == 2) begin
                in_valid = 1'b1;
                A = 16'h1111;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk({name, "_latency"}, 64'(n), 64'(NDIG));
        chk({name, "_P"}, 64'(P), 64'(exp_p));
        for (int c = 0; c < hold; c++) tick();
        if (hold > 0) begin
            chk({name, "_held_P"}, 64'(P), 64'(exp_p));
            chk({name, "_held_valid"}, 64'(out_valid), 64'd1);
            chk({name, "_held_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_after_hs_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_after_hs_in_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_after_hs_P_kept"}, 64'(P), 64'(exp_p));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with garbage inputs active
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        A = 16'hFFFF;
        i_val = 16'hFFFF;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_P", 64'(P), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();

        run_op("small", 16'h0003, 16'd5, 32'h0000000F, 0, 1'b0);
        run_op("alldigits", 16'h7D63, 16'd3, 32'h00017829, 0, 1'b0);
        run_op("mixed", 16'h8421, 16'h1234, 32'h096528B4, 2, 1'b0);
        run_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1'b0);
        run_op("zeroA", 16'h0000, 16'hFFFF, 32'h00000000, 0, 1'b0);
        run_op("backpressure", 16'h0102, 16'h0304, 32'h00030A08, 10, 1'b1);

        // Abort mid-run: three digits processed, then reset
        A = 16'hFFFF;
        i_val = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_P", 64'(P), 64'd0);
        tick();

        run_op("after_abort", 16'h0002, 16'd7, 32'h0000000E, 0, 1'b0);

        // Idle input changes must not disturb anything
        A = 16'h1357;
        i_val = 16'h2468;
        tick();
        tick();
        chk("idle_P_stable", 64'(P), 64'h0000000E);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
